// File: rtl/fft_bfly_sched.sv
// fft_bfly_sched: sequences in-place radix-2 DIT FFT stages through one shared butterfly.
// Issues read pairs and twiddle indices, and replays the pair as the write-back after the pipeline latency.
module fft_bfly_sched #(
  parameter int LOGN   = 3,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            en,
  output logic            busy,
  output logic            done,
  output logic [LOGN-1:0] stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_addr,
  output logic            bf_ce,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int HALF = 1 << (LOGN - 1);
  localparam int DLY  = RD_LAT + BF_LAT;
  localparam int DW   = $clog2(DLY + 1);
  localparam int TWW  = LOGN - 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [LOGN-1:0] s_reg, s_next;
  logic [LOGN-1:0] k_reg, k_next;
  logic [DW-1:0]   dcnt_reg, dcnt_next;

  logic [LOGN-1:0] ra_reg, rb_reg;
  logic [TWW-1:0]  tw_reg;

  logic            vld_pipe [DLY];
  logic [LOGN-1:0] pa_pipe  [DLY];
  logic [LOGN-1:0] pb_pipe  [DLY];

  function automatic logic [LOGN-1:0] addr_a_f(input logic [LOGN-1:0] s, input logic [LOGN-1:0] k);
    int si, ki, span;
    si   = int'(s);
    ki   = int'(k);
    span = 1 << si;
    return LOGN'(((ki >> si) << (si + 1)) | (ki & (span - 1)));
  endfunction

  function automatic logic [LOGN-1:0] addr_b_f(input logic [LOGN-1:0] s, input logic [LOGN-1:0] k);
    return LOGN'(int'(addr_a_f(s, k)) + (1 << int'(s)));
  endfunction

  function automatic logic [TWW-1:0] tw_f(input logic [LOGN-1:0] s, input logic [LOGN-1:0] k);
    int si, ki;
    si = int'(s);
    ki = int'(k);
    return TWW'((ki & ((1 << si) - 1)) << (LOGN - 1 - si));
  endfunction

  // State and counters only advance on en; en=0 freezes the whole schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      k_reg     <= '0;
      dcnt_reg  <= '0;
    end else if (en) begin
      state_reg <= state_next;
      s_reg     <= s_next;
      k_reg     <= k_next;
      dcnt_reg  <= dcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    k_next     = k_reg;
    dcnt_next  = dcnt_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          s_next     = '0;
          k_next     = '0;
        end
      end
      ISSUE: begin
        if (k_reg == LOGN'(HALF - 1)) begin
          state_next = DRAIN;
          dcnt_next  = DW'(DLY);
        end else begin
          k_next = k_reg + LOGN'(1);
        end
      end
      DRAIN: begin
        // The gap lets the last write of stage s land before stage s+1 reads it.
        if (dcnt_reg == DW'(1)) begin
          if (int'(s_reg) < LOGN - 1) begin
            state_next = ISSUE;
            s_next     = s_reg + LOGN'(1);
            k_next     = '0;
          end else begin
            state_next = DONE;
          end
        end else begin
          dcnt_next = dcnt_reg - DW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Addresses are registered for the butterfly about to be issued, then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_reg <= '0;
      rb_reg <= '0;
      tw_reg <= '0;
    end else if (en && state_next == ISSUE) begin
      ra_reg <= addr_a_f(s_next, k_next);
      rb_reg <= addr_b_f(s_next, k_next);
      tw_reg <= tw_f(s_next, k_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) begin
        vld_pipe[i] <= 1'b0;
        pa_pipe[i]  <= '0;
        pb_pipe[i]  <= '0;
      end
    end else if (en) begin
      vld_pipe[0] <= (state_reg == ISSUE);
      pa_pipe[0]  <= ra_reg;
      pb_pipe[0]  <= rb_reg;
      for (int i = 1; i < DLY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pa_pipe[i]  <= pa_pipe[i-1];
        pb_pipe[i]  <= pb_pipe[i-1];
      end
    end
  end

  always_comb begin
    busy      = (state_reg == ISSUE) || (state_reg == DRAIN);
    done      = (state_reg == DONE);
    stage     = s_reg;
    rd_en     = (state_reg == ISSUE) && en;
    rd_addr_a = ra_reg;
    rd_addr_b = rb_reg;
    tw_addr   = tw_reg;
    bf_ce     = vld_pipe[RD_LAT-1] && en;
    wr_en     = vld_pipe[DLY-1] && en;
    wr_addr_a = pa_pipe[DLY-1];
    wr_addr_b = pb_pipe[DLY-1];
  end

endmodule

// File: tb/tb_fft_bfly_sched.sv
// tb_fft_bfly_sched: checks two scheduler configurations against a cycle-level model
// built from stage/group enumeration of the butterfly pairs.
module tb_fft_bfly_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic en = 1'b0;

  logic       busy0, done0, rd0, bf0, wr0;
  logic [2:0] st0, ra0, rb0, wa0, wb0;
  logic [1:0] tw0;
  logic       busy1, done1, rd1, bf1, wr1;
  logic [3:0] st1, ra1, rb1, wa1, wb1;
  logic [2:0] tw1;

  always #5 clk = ~clk;

  fft_bfly_sched #(.LOGN(3), .RD_LAT(1), .BF_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en),
    .busy(busy0), .done(done0), .stage(st0), .rd_en(rd0),
    .rd_addr_a(ra0), .rd_addr_b(rb0), .tw_addr(tw0), .bf_ce(bf0),
    .wr_en(wr0), .wr_addr_a(wa0), .wr_addr_b(wb0)
  );

  fft_bfly_sched #(.LOGN(4), .RD_LAT(2), .BF_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .en(en),
    .busy(busy1), .done(done1), .stage(st1), .rd_en(rd1),
    .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1), .bf_ce(bf1),
    .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1)
  );

  int errors = 0;
  int checks = 0;

  int sel, lg, rl, dly, half, per, tot;
  bit started;
  int e;
  bit hv [4];
  int ha [4];
  int hb [4];
  int la [$];
  int lb [$];
  int lt [$];
  int busy_cnt, done_cnt, last_wa, last_wb;
  int o_busy, o_done, o_rd, o_bf, o_wr, o_st, o_ra, o_rb, o_tw, o_wa, o_wb;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected butterfly order: per stage, walk groups of width 2*span, pairing j with j+span.
  task automatic configure(input int s);
    int n, span;
    sel  = s;
    lg   = (s == 0) ? 3 : 4;
    rl   = (s == 0) ? 1 : 2;
    dly  = rl + 1;
    half = 1 << (lg - 1);
    per  = half + dly;
    tot  = lg * per;
    n    = 1 << lg;
    la.delete(); lb.delete(); lt.delete();
    for (int st = 0; st < lg; st++) begin
      span = 1 << st;
      for (int base = 0; base < n; base += 2 * span)
        for (int j = 0; j < span; j++) begin
          la.push_back(base + j);
          lb.push_back(base + j + span);
          lt.push_back(j * (n / (2 * span)));
        end
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      o_busy = int'(busy0); o_done = int'(done0); o_rd = int'(rd0); o_bf = int'(bf0);
      o_wr = int'(wr0); o_st = int'(st0); o_ra = int'(ra0); o_rb = int'(rb0);
      o_tw = int'(tw0); o_wa = int'(wa0); o_wb = int'(wb0);
    end else begin
      o_busy = int'(busy1); o_done = int'(done1); o_rd = int'(rd1); o_bf = int'(bf1);
      o_wr = int'(wr1); o_st = int'(st1); o_ra = int'(ra1); o_rb = int'(rb1);
      o_tw = int'(tw1); o_wa = int'(wa1); o_wb = int'(wb1);
    end
  endtask

  task automatic clear_model();
    started = 1'b0;
    e = 0;
    for (int i = 0; i < 4; i++) begin
      hv[i] = 1'b0; ha[i] = 0; hb[i] = 0;
    end
  endtask

  task automatic check_zero(input string tag);
    sample();
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_rd_en"}, o_rd, 0);
    chk({tag, "_bf_ce"}, o_bf, 0);
    chk({tag, "_wr_en"}, o_wr, 0);
    chk({tag, "_stage"}, o_st, 0);
    chk({tag, "_rd_pair"}, o_ra + 16 * o_rb + 256 * o_tw, 0);
    chk({tag, "_wr_pair"}, o_wa + 16 * o_wb, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; en = 1'b0;
    clear_model();
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: inputs held from just after one rising edge to the next.
  task automatic cyc(input bit st, input bit env);
    bit idle, issue;
    int j;
    start = st;
    en    = env;
    @(negedge clk);
    sample();
    idle  = !started || e > tot;
    issue = started && e < tot && (e % per) < half;
    j     = issue ? (e / per) * half + (e % per) : 0;
    chk("busy", o_busy, int'(started && e < tot));
    chk("done", o_done, int'(started && e == tot));
    chk("rd_en", o_rd, int'(issue && env));
    if (issue) begin
      chk("rd_addr_a", o_ra, la[j]);
      chk("rd_addr_b", o_rb, lb[j]);
      chk("tw_addr", o_tw, lt[j]);
      chk("stage", o_st, e / per);
    end
    chk("bf_ce", o_bf, int'(env && hv[rl-1]));
    chk("wr_en", o_wr, int'(env && hv[dly-1]));
    if (env && hv[dly-1]) begin
      chk("wr_addr_a", o_wa, ha[dly-1]);
      chk("wr_addr_b", o_wb, hb[dly-1]);
    end
    if (o_busy != 0) busy_cnt++;
    if (o_done != 0) done_cnt++;
    if (o_wr != 0) begin
      last_wa = o_wa; last_wb = o_wb;
    end
    @(posedge clk);
    if (env) begin
      for (int i = 3; i > 0; i--) begin
        hv[i] = hv[i-1]; ha[i] = ha[i-1]; hb[i] = hb[i-1];
      end
      hv[0] = issue;
      ha[0] = issue ? la[j] : 0;
      hb[0] = issue ? lb[j] : 0;
      if (idle && st) begin
        started = 1'b1;
        e = 0;
      end else if (started) begin
        e++;
      end
    end
    #1;
  endtask

  // mode 0: plain run; 1: 3-cycle en freeze at stage 1 k=1; 2: stray starts in ISSUE and DONE.
  task automatic run(input int mode, input int exp_busy);
    int n, frz;
    bit st, env;
    busy_cnt = 0; done_cnt = 0; n = 0; frz = 0;
    cyc(1'b1, 1'b1);
    while (!(started && e > tot + 1) && n < 400) begin
      st = 1'b0; env = 1'b1;
      if (mode == 1 && e == per + 1 && frz < 3) begin
        env = 1'b0; frz++;
      end
      if (mode == 2 && (e == 2 || e == tot)) st = 1'b1;
      cyc(st, env);
      n++;
    end
    chk("run_timeout", int'(n < 400), 1);
    chk("busy_cycles", busy_cnt, exp_busy);
    chk("done_pulses", done_cnt, 1);
  endtask

  task automatic random_run(input int ncyc);
    cyc(1'b1, 1'b1);
    for (int i = 0; i < ncyc; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
  endtask

  initial begin
    configure(0);
    do_reset();
    run(0, 18);
    do_reset();
    run(1, 21);
    do_reset();
    run(2, 18);

    // Abort at stage 1, k=2, then confirm a clean replay from stage 0.
    do_reset();
    busy_cnt = 0; done_cnt = 0;
    cyc(1'b1, 1'b1);
    for (int i = 0; i < 50 && !(started && e == per + 2); i++) cyc(1'b0, 1'b1);
    chk("abort_point", e, per + 2);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    clear_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(0, 18);

    configure(1);
    do_reset();
    last_wa = -1; last_wb = -1;
    run(0, 44);
    chk("last_wr_a", last_wa, 7);
    chk("last_wr_b", last_wb, 15);
    do_reset();
    random_run(250);

    configure(0);
    do_reset();
    random_run(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
